instr_fetch_unit: RTL and testbench

//  Upstream fetch stage of the single-cycle LEGv8 core. Holds the PC, fetches 32-bit

---
 rtl/instr_fetch_unit_pkg.sv | 17 +
 rtl/instr_fetch_unit_if.sv | 33 +++
 rtl/instr_fetch_unit_next_pc.sv | 23 ++
 rtl/instr_fetch_unit.sv | 77 +++++++
 tb/tb_instr_fetch_unit.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the LEGv8 fetch stage.
// Holds the FSM encoding, default bus widths and the opcode field bounds.
package instr_fetch_unit_pkg;

  localparam int PC_WIDTH_DEF    = 64;
  localparam int INSTR_WIDTH_DEF = 32;
  localparam int OPC_HI          = 31;
  localparam int OPC_LO          = 21;
  localparam int OPC_WIDTH       = OPC_HI - OPC_LO + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: the instruction-memory port, the decoder outputs and the commit/branch inputs.
// The master modport is the fetch unit, and the slave modport is the memory/datapath side.
interface instr_fetch_unit_if
  import instr_fetch_unit_pkg::*;
#(
  parameter int PC_WIDTH    = PC_WIDTH_DEF,
  parameter int INSTR_WIDTH = INSTR_WIDTH_DEF
);
  logic                   imem_req;
  logic [PC_WIDTH-1:0]    imem_addr;
  logic                   imem_ack;
  logic [INSTR_WIDTH-1:0] imem_rdata;
  logic [INSTR_WIDTH-1:0] instr;
  logic [OPC_WIDTH-1:0]   opcode;
  logic                   instr_valid;
  logic                   commit;
  logic                   branch;
  logic                   uncond_branch;
  logic                   zero;
  logic [PC_WIDTH-1:0]    sign_ext_imm;
  logic [PC_WIDTH-1:0]    pc;
  logic                   fetch_timeout;

  modport master (
    output imem_req, imem_addr, instr, opcode, instr_valid, pc, fetch_timeout,
    input  imem_ack, imem_rdata, commit, branch, uncond_branch, zero, sign_ext_imm
  );

  modport slave (
    input  imem_req, imem_addr, instr, opcode, instr_valid, pc, fetch_timeout,
    output imem_ack, imem_rdata, commit, branch, uncond_branch, zero, sign_ext_imm
  );
endinterface

// File: rtl/instr_fetch_unit_next_pc.sv
// next_pc_logic: combinational PC successor (pc+4 or pc + offset*4, wrapping).
// Zero latency; no handshake. uncond_branch is resolved first so an X on branch cannot leak.
module next_pc_logic #(
  parameter int PC_WIDTH = 64
) (
  input  logic [PC_WIDTH-1:0] pc,
  input  logic [PC_WIDTH-1:0] sign_ext_imm,
  input  logic                branch,
  input  logic                uncond_branch,
  input  logic                zero,
  output logic [PC_WIDTH-1:0] next_pc
);
  logic                take;
  logic [PC_WIDTH-1:0] offset;

  always_comb begin
    take = 1'b0;
    if (uncond_branch) take = 1'b1;
    else               take = branch & zero;
    offset  = take ? {sign_ext_imm[PC_WIDTH-3:0], 2'b00} : PC_WIDTH'(4);
    next_pc = pc + offset;
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// LEGv8 fetch stage: PC register, req/ack instruction fetch, and instruction hold until commit.
// Ack in cycle N gives instr_valid in N+1. The request is held until ack, and instr is held until commit.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int                  PC_WIDTH    = PC_WIDTH_DEF,
  parameter int                  INSTR_WIDTH = INSTR_WIDTH_DEF,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
  parameter int                  MAX_WAIT    = 15
) (
  input  logic                CLK,
  input  logic                Reset,
  instr_fetch_unit_if.master  bus
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_MAX  = CW'(MAX_WAIT);
  localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

  fetch_state_t           state;
  logic [PC_WIDTH-1:0]    pc;
  logic [PC_WIDTH-1:0]    next_pc;
  logic [INSTR_WIDTH-1:0] instr;
  logic [CW-1:0]          wait_cnt;
  logic                   fetch_timeout;

  next_pc_logic #(.PC_WIDTH(PC_WIDTH)) u_next_pc (
    .pc            (pc),
    .sign_ext_imm  (bus.sign_ext_imm),
    .branch        (bus.branch),
    .uncond_branch (bus.uncond_branch),
    .zero          (bus.zero),
    .next_pc       (next_pc)
  );

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state         <= ST_IDLE;
      pc            <= RESET_PC;
      instr         <= '0;
      wait_cnt      <= '0;
      fetch_timeout <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          state    <= ST_FETCH;
          wait_cnt <= '0;
        end
        ST_FETCH: begin
          if (bus.imem_ack) begin
            instr <= bus.imem_rdata;
            state <= ST_HOLD;
          end else begin
            if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + CW'(1);
            // This edge closes the MAX_WAIT-th consecutive un-acked cycle.
            if (wait_cnt >= WAIT_LAST) fetch_timeout <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (bus.commit) begin
            pc       <= next_pc;
            state    <= ST_FETCH;
            wait_cnt <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.imem_req      = (state == ST_FETCH);
  assign bus.instr_valid   = (state == ST_HOLD);
  assign bus.imem_addr     = pc;
  assign bus.pc            = pc;
  assign bus.instr         = instr;
  assign bus.opcode        = instr[OPC_HI:OPC_LO];
  assign bus.fetch_timeout = fetch_timeout;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios followed by random traffic,
// with a transaction-level model of the PC, the held instruction and the timeout.
module tb_instr_fetch_unit;
  localparam int MAX_WAIT = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  // Reference model state.
  logic [63:0] m_pc;
  logic [31:0] m_instr;
  bit          m_waiting;
  bit          m_holding;
  int          m_unacked;
  bit          m_tout;

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(.MAX_WAIT(MAX_WAIT)) dut (
    .CLK   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    bit take;
    if (rst) begin
      m_pc = 64'd0; m_instr = 32'd0; m_waiting = 0; m_holding = 0;
      m_unacked = 0; m_tout = 0;
    end else if (m_waiting) begin
      if (bus.imem_ack === 1'b1) begin
        m_instr = bus.imem_rdata; m_waiting = 0; m_holding = 1;
      end else begin
        m_unacked++;
        if (m_unacked >= MAX_WAIT) m_tout = 1;
      end
    end else if (m_holding) begin
      if (bus.commit === 1'b1) begin
        if (bus.uncond_branch === 1'b1) take = 1;
        else take = (bus.branch === 1'b1) && (bus.zero === 1'b1);
        m_pc = take ? m_pc + bus.sign_ext_imm * 64'd4 : m_pc + 64'd4;
        m_holding = 0; m_waiting = 1; m_unacked = 0;
      end
    end else begin
      m_waiting = 1; m_unacked = 0;
    end
  endtask

  task automatic compare_all();
    check_val("req",    64'(bus.imem_req),      64'(m_waiting));
    check_val("addr",   bus.imem_addr,          m_pc);
    check_val("valid",  64'(bus.instr_valid),   64'(m_holding));
    check_val("instr",  64'(bus.instr),         64'(m_instr));
    check_val("opcode", 64'(bus.opcode),        64'((m_instr >> 21) & 32'h7FF));
    check_val("pc",     bus.pc,                 m_pc);
    check_val("tout",   64'(bus.fetch_timeout), 64'(m_tout));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_inputs();
    bus.imem_ack = 0; bus.imem_rdata = $urandom; bus.commit = 0;
    bus.branch = 0; bus.uncond_branch = 0; bus.zero = 0; bus.sign_ext_imm = '0;
  endtask

  task automatic fetch_to_hold(input int waits);
    bus.imem_ack = 0;
    for (int i = 0; i < waits; i++) tick();
    bus.imem_ack = 1; bus.imem_rdata = $urandom;
    tick();
    bus.imem_ack = 0;
  endtask

  task automatic do_commit(input logic br, input logic ub, input logic zr, input logic [63:0] imm);
    bus.commit = 1; bus.branch = br; bus.uncond_branch = ub; bus.zero = zr; bus.sign_ext_imm = imm;
    tick();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    m_pc = '0; m_instr = '0; m_waiting = 0; m_holding = 0; m_unacked = 0; m_tout = 0;

    // 1: reset, first fetch, sequential commit.
    rst = 1; tick(); tick();
    rst = 0; tick();
    check_val("t1_addr0", bus.imem_addr, 64'd0);
    tick();
    bus.imem_ack = 1; bus.imem_rdata = 32'h8B020020; tick(); bus.imem_ack = 0;
    check_val("t1_opcode", 64'(bus.opcode), 64'h458);
    check_val("t1_valid", 64'(bus.instr_valid), 64'd1);
    do_commit(0, 0, 0, 64'd0);
    check_val("t1_pc4", bus.pc, 64'd4);
    check_val("t1_req4", 64'(bus.imem_req), 64'd1);

    // 2: unconditional branch with X on branch.
    fetch_to_hold(0); do_commit(0, 1, 0, 64'd3);
    check_val("t2_pc10", bus.pc, 64'h10);
    fetch_to_hold(1); do_commit(1'bx, 1, 0, -64'sd3);
    check_val("t2_pc04", bus.pc, 64'h04);

    // 3: conditional branch taken and not taken.
    fetch_to_hold(0); do_commit(0, 1, 0, 64'd7);
    fetch_to_hold(0); do_commit(1, 0, 1, 64'd5);
    check_val("t3_taken", bus.pc, 64'h34);
    fetch_to_hold(0); do_commit(0, 1, 0, -64'sd5);
    fetch_to_hold(0); do_commit(1, 0, 0, 64'd5);
    check_val("t3_not_taken", bus.pc, 64'h24);

    // 4: ack withheld 20 cycles.
    for (int i = 0; i < MAX_WAIT - 1; i++) tick();
    check_val("t4_tout_early", 64'(bus.fetch_timeout), 64'd0);
    tick();
    check_val("t4_tout_set", 64'(bus.fetch_timeout), 64'd1);
    for (int i = 0; i < 5; i++) tick();
    check_val("t4_req_held", 64'(bus.imem_req), 64'd1);
    check_val("t4_addr_held", bus.imem_addr, 64'h24);
    fetch_to_hold(0);
    check_val("t4_valid", 64'(bus.instr_valid), 64'd1);
    do_commit(0, 0, 0, 64'd0);
    check_val("t4_tout_sticky", 64'(bus.fetch_timeout), 64'd1);

    // 5: reset mid-HOLD and mid-FETCH.
    fetch_to_hold(0);
    rst = 1; tick(); rst = 0;
    check_val("t5_hold_valid", 64'(bus.instr_valid), 64'd0);
    check_val("t5_hold_pc", bus.pc, 64'd0);
    tick(); tick();
    rst = 1; tick(); rst = 0;
    check_val("t5_fetch_req", 64'(bus.imem_req), 64'd0);
    tick();
    check_val("t5_refetch", bus.imem_addr, 64'd0);

    // 6: PC wrap, then commit and ack outside their states.
    fetch_to_hold(0); do_commit(0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF);
    check_val("t6_pc_top", bus.pc, 64'hFFFF_FFFF_FFFF_FFFC);
    fetch_to_hold(0); do_commit(0, 0, 0, 64'd0);
    check_val("t6_wrap", bus.pc, 64'd0);
    bus.commit = 1; bus.uncond_branch = 1; bus.sign_ext_imm = 64'd9; tick(); idle_inputs();
    check_val("t6_commit_fetch", bus.pc, 64'd0);
    fetch_to_hold(0);
    bus.imem_ack = 1; bus.imem_rdata = ~bus.instr; tick(); bus.imem_ack = 0;

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      bus.imem_ack = ($urandom_range(0, 2) == 0);
      bus.imem_rdata = $urandom;
      bus.commit = $urandom_range(0, 1);
      bus.branch = $urandom_range(0, 1);
      bus.uncond_branch = ($urandom_range(0, 3) == 0);
      bus.zero = $urandom_range(0, 1);
      bus.sign_ext_imm = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom}
                                                     : 64'($signed(12'($urandom)));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
